// File: rtl/barrett_pkg.sv
// Shared definitions for the sequential Barrett modular multiplier:
// FSM state encoding and elaboration-time sizing helpers.
package barrett_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_CORR = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Number of radix-2^W digits needed to cover an n-bit operand.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Digit counter width; kept at least one bit so K = 1 still has a counter.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/barrett_step.sv
// One Barrett digit step: T = Z*2^W + X*y, q = estimated floor(T/M),
// Z_next = T - q*M (lands in [0, 4M) because q undershoots by at most 3).
module barrett_step #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic [N+1:0] i_z,
  input  logic [N-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [N-1:0] i_m,
  input  logic [W+3:0] i_mu,
  output logic [W+2:0] o_q,
  output logic [N+1:0] o_z_next
);

  localparam int TW = N + W + 3;
  localparam int HW = W + 4;
  localparam int PW = 2 * W + 8;
  localparam int QW = W + 3;
  localparam int ZW = N + 2;

  logic [TW-1:0] w_t;
  logic [TW-1:0] w_qm;
  logic [HW-1:0] w_t_hi;
  logic [PW-1:0] w_prod;
  logic [QW-1:0] w_q;

  assign w_t    = (TW'(i_z) << W) + TW'(i_x) * TW'(i_y);
  // Only the top bits of T feed the quotient estimate; the truncation is
  // what bounds the undershoot.
  assign w_t_hi = HW'(w_t >> (N - 1));
  assign w_prod = PW'(w_t_hi) * PW'(i_mu);
  assign w_q    = QW'(w_prod >> (W + 3));
  assign w_qm   = TW'(w_q) * TW'(i_m);

  assign o_q      = w_q;
  assign o_z_next = ZW'(w_t - w_qm);

endmodule

// File: rtl/barrett_mm_seq.sv
// Sequential Barrett modular multiplier: consumes Y one radix-2^W digit per
// cycle (MSD first), then subtracts M until the partial result is reduced.
module barrett_mm_seq
  import barrett_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  input  logic [N-1:0]   M,
  input  logic [W+3:0]   mu,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [N-1:0]   Z_OUT,
  output logic [W+2:0]   q_i
);

  localparam int K     = ceil_div(N, W);
  localparam int KW    = K * W;
  localparam int CNT_W = cnt_width(K);
  localparam int ZW    = N + 2;

  state_t            r_state;
  state_t            w_state_next;
  logic [N-1:0]      r_x;
  logic [KW-1:0]     r_y;
  logic [N-1:0]      r_m;
  logic [W+3:0]      r_mu;
  logic [ZW-1:0]     r_z;
  logic [CNT_W-1:0]  r_cnt;
  logic [N-1:0]      r_zout;
  logic [W+2:0]      r_q;
  logic              r_err;

  logic              w_bad;
  logic              w_z_ge_m;
  logic              w_last;
  logic [W-1:0]      w_y_dig;
  logic [W-1:0]      w_digits [K];
  logic [W+2:0]      w_q;
  logic [ZW-1:0]     w_z_next;

  for (genvar gi = 0; gi < K; gi++) begin : g_digit
    assign w_digits[gi] = r_y[gi*W +: W];
  end

  assign w_y_dig  = w_digits[r_cnt];
  assign w_bad    = ~M[N-1] | (X >= M) | (Y >= M);
  assign w_z_ge_m = (r_z >= {2'b00, r_m});
  assign w_last   = (r_cnt == '0);

  barrett_step #(
    .N (N),
    .W (W)
  ) u_step (
    .i_z      (r_z),
    .i_x      (r_x),
    .i_y      (w_y_dig),
    .i_m      (r_m),
    .i_mu     (r_mu),
    .o_q      (w_q),
    .o_z_next (w_z_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = w_bad ? ST_DONE : ST_ITER;
        end
      end
      ST_ITER: begin
        if (w_last) begin
          w_state_next = ST_CORR;
        end
      end
      ST_CORR: begin
        if (!w_z_ge_m) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x    <= '0;
      r_y    <= '0;
      r_m    <= '0;
      r_mu   <= '0;
      r_z    <= '0;
      r_cnt  <= '0;
      r_zout <= '0;
      r_q    <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x   <= X;
            r_y   <= KW'(Y);
            r_m   <= M;
            r_mu  <= mu;
            r_z   <= '0;
            r_cnt <= CNT_W'(K - 1);
            r_err <= w_bad;
            // Illegal operands skip the datapath entirely and report zero.
            if (w_bad) begin
              r_zout <= '0;
            end
          end
        end
        ST_ITER: begin
          r_z <= w_z_next;
          r_q <= w_q;
          if (!w_last) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CORR: begin
          if (w_z_ge_m) begin
            r_z <= r_z - {2'b00, r_m};
          end else begin
            r_zout <= r_z[N-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign done  = (r_state == ST_DONE);
  assign err   = r_err;
  assign Z_OUT = r_zout;
  assign q_i   = r_q;

endmodule

// File: tb/tb_barrett_mm_seq.sv
// Self-checking bench for barrett_mm_seq (N=8, W=4): directed cases, busy and
// reset abuse, and randomized operands against plain (X*Y) mod M arithmetic.
module tb_barrett_mm_seq;

  localparam int N = 8;
  localparam int W = 4;
  localparam int K = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] X, Y, M, mu;
  logic       busy, done, err;
  logic [7:0] Z_OUT;
  logic [6:0] q_i;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] r_z;
  logic       r_e;
  logic [6:0] r_q1, r_q2;
  int         lat;
  int         n_done;
  logic [7:0] z_cap;
  logic       e_cap;
  logic [7:0] rx, ry, rm, rmu;

  always #5 CLK = ~CLK;

  barrett_mm_seq #(.N(N), .W(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .X     (X),
    .Y     (Y),
    .M     (M),
    .mu    (mu),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .Z_OUT (Z_OUT),
    .q_i   (q_i)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issues one operation from IDLE and waits (bounded) for done.
  // lat counts rising edges after the edge that samples start.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] m,
                        input logic [7:0] muv, output logic [7:0] z, output logic e,
                        output int l, output logic [6:0] q1, output logic [6:0] q2);
    X = x; Y = y; M = m; mu = muv; start = 1'b1;
    tick();
    start = 1'b0;
    l = 0; q1 = '0; q2 = '0;
    while (!done && l < 20) begin
      tick();
      l++;
      if (l == 1) q1 = q_i;
      if (l == 2) q2 = q_i;
    end
    check_val("done_seen", done, 1);
    z = Z_OUT;
    e = err;
    $display("op x=%0d y=%0d m=%0d mu=%0d -> z=%0d err=%0d lat=%0d", x, y, m, muv, z, e, l);
    if (done) begin
      tick();
      check_val("done_one_cycle", done, 0);
      check_val("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; X = '0; Y = '0; M = '0; mu = '0;
    tick();
    tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_zout", Z_OUT, 0);
    check_val("rst_qi", q_i, 0);
    RST = 1'b0;
    tick();

    // Worked example: two iterations, one correction subtraction.
    run_op(8'd100, 8'd150, 8'd197, 8'd83, r_z, r_e, lat, r_q1, r_q2);
    check_val("ex_q1", r_q1, 4);
    check_val("ex_q2", r_q2, 11);
    check_val("ex_z", r_z, 28);
    check_val("ex_err", r_e, 0);
    check_val("ex_lat", lat, 4);

    run_op(8'd254, 8'd254, 8'd255, 8'd64, r_z, r_e, lat, r_q1, r_q2);
    check_val("m255_z", r_z, 1);
    check_val("m255_err", r_e, 0);

    run_op(8'd0, 8'd196, 8'd197, 8'd83, r_z, r_e, lat, r_q1, r_q2);
    check_val("x0_z", r_z, 0);
    check_val("x0_lat", lat, 3);

    // Error path: done appears in the cycle right after the start cycle.
    run_op(8'd10, 8'd20, 8'h45, 8'd83, r_z, r_e, lat, r_q1, r_q2);
    check_val("msb_err", r_e, 1);
    check_val("msb_z", r_z, 0);
    check_val("msb_lat", lat, 0);

    run_op(8'd197, 8'd5, 8'd197, 8'd83, r_z, r_e, lat, r_q1, r_q2);
    check_val("xeqm_err", r_e, 1);
    check_val("xeqm_z", r_z, 0);
    check_val("xeqm_lat", lat, 0);

    // Start and operands toggled while busy; start also held in the DONE cycle.
    X = 8'd100; Y = 8'd150; M = 8'd197; mu = 8'd83; start = 1'b1;
    tick();
    n_done = 0; z_cap = '0; e_cap = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        n_done++;
        z_cap = Z_OUT;
        e_cap = err;
        start = 1'b1;
        X = 8'($urandom); Y = 8'($urandom); M = 8'($urandom); mu = 8'($urandom);
      end else if (n_done > 0) begin
        start = 1'b0;
      end else begin
        start = 1'($urandom);
        X = 8'($urandom); Y = 8'($urandom); M = 8'($urandom); mu = 8'($urandom);
      end
      tick();
    end
    start = 1'b0;
    $display("busy-toggle op -> dones=%0d z=%0d err=%0d", n_done, z_cap, e_cap);
    check_val("busy_done_count", n_done, 1);
    check_val("busy_z", z_cap, 28);
    check_val("busy_err", e_cap, 0);

    // Reset in the middle of ITER aborts the operation.
    X = 8'd100; Y = 8'd150; M = 8'd197; mu = 8'd83; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_err", err, 0);
    check_val("abort_zout", Z_OUT, 0);
    check_val("abort_qi", q_i, 0);
    tick();
    RST = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    $display("abort op -> dones=%0d", n_done);
    check_val("abort_no_done", n_done, 0);
    run_op(8'd100, 8'd150, 8'd197, 8'd83, r_z, r_e, lat, r_q1, r_q2);
    check_val("post_abort_z", r_z, 28);

    // Randomized legal operands with mu computed from the modulus.
    for (int i = 0; i < 10000; i++) begin
      rm  = 8'($urandom_range(128, 255));
      rx  = 8'($urandom % rm);
      ry  = 8'($urandom % rm);
      rmu = 8'((32'd1 << 14) / rm);
      run_op(rx, ry, rm, rmu, r_z, r_e, lat, r_q1, r_q2);
      check_val("rand_z", r_z, (int'(rx) * int'(ry)) % int'(rm));
      check_val("rand_err", r_e, 0);
      check_val("rand_lat_in_range", (lat >= K + 1 && lat <= K + 4) ? 1 : 0, 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
